// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// The FSM state encoding and iteration/count sizing live here so the datapath and bench agree.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_DZ   = 3'd4
    } div_state_e;

    // Counter must hold values 0..WIDTH, hence one bit more than log2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;
    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_seq_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_seq_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/twos_neg.sv
// Conditional two's-complement negation, truncated to WIDTH bits.
// Used both for operand magnitudes and for the final sign fix-up.
module twos_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;
endmodule

// File: rtl/div_seq.sv
// Restoring sequential signed divider with MIPS div semantics: lo = quotient, hi = remainder.
// One quotient bit per cycle; divide-by-zero is reported instead of producing a result.
module div_seq import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    div_seq_if.slave bus
);
    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    twos_neg #(.WIDTH(WIDTH)) u_dvd_abs (
        .a_i(bus.dividend), .neg_i(bus.dividend[WIDTH-1]), .y_o(dvd_abs));
    twos_neg #(.WIDTH(WIDTH)) u_dvs_abs (
        .a_i(bus.divisor),  .neg_i(bus.divisor[WIDTH-1]),  .y_o(dvs_abs));
    twos_neg #(.WIDTH(WIDTH)) u_quo_fix (
        .a_i(quo_q), .neg_i(sign_q_q), .y_o(quo_fix));
    twos_neg #(.WIDTH(WIDTH)) u_rem_fix (
        .a_i(rem_q), .neg_i(sign_r_q), .y_o(rem_fix));

    // Shifted remainder never exceeds 2*dvs-1, so a WIDTH+1 bit difference's MSB is the borrow.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    end

    // NOTE: every register here uses <= so all updates see pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= S_DZ;
                        end else begin
                            quo_q    <= dvd_abs;
                            dvs_q    <= dvs_abs;
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            sign_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_r_q <= bus.dividend[WIDTH-1];
                            busy_q   <= 1'b1;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_q    <= quo_fix;
                    hi_q    <= rem_fix;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_DZ: begin
                    dz_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule
